// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ requesters.
// Launches one word per grant, then holds the link busy for the frame plus an idle gap.
module uart_tx_arbiter #(
  parameter int N_REQ    = 3,
  parameter int WIDTH    = 16,
  parameter int BAUD_DIV = 100,
  parameter int GAP_BITS = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]       grant,
  output logic [WIDTH-1:0]       tx_data,
  output logic                   tx_start,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             sent_cnt
);
  localparam int FRAME_CYC = (WIDTH + 2) * BAUD_DIV;
  localparam int GAP_CYC   = GAP_BITS * BAUD_DIV;
  localparam int MAX_CYC   = (FRAME_CYC > GAP_CYC) ? FRAME_CYC : GAP_CYC;
  localparam int CNT_W     = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int PTR_W     = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;

  logic               hi_vld, lo_vld;
  logic [PTR_W-1:0]   hi_idx, lo_idx, pick_idx;
  logic [WIDTH-1:0]   hi_data, lo_data, pick_data;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
    return (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + PTR_W'(1);
  endfunction

  // Lowest set request at or above ptr wins; otherwise wrap to the lowest set request overall.
  always_comb begin
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    hi_idx  = '0;
    lo_idx  = '0;
    hi_data = '0;
    lo_data = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_vld  = 1'b1;
        lo_idx  = PTR_W'(i);
        lo_data = data_in[i*WIDTH +: WIDTH];
        if (PTR_W'(i) >= ptr) begin
          hi_vld  = 1'b1;
          hi_idx  = PTR_W'(i);
          hi_data = data_in[i*WIDTH +: WIDTH];
        end
      end
    end
    pick_idx  = hi_vld ? hi_idx  : lo_idx;
    pick_data = hi_vld ? hi_data : lo_data;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      grant    <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sent_cnt <= 8'd0;
    end else begin
      grant    <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (lo_vld) begin
            grant    <= N_REQ'(1) << pick_idx;
            tx_data  <= pick_data;
            tx_start <= 1'b1;
            busy     <= 1'b1;
            sent_cnt <= sent_cnt + 8'd1;
            ptr      <= next_ptr(pick_idx);
            cnt      <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (cnt == FRAME_LAST) begin
            done <= 1'b1;
            cnt  <= '0;
            if (GAP_CYC == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a slow-baud instance for arbitration and timing,
// and a BAUD_DIV=1 instance for 256 back-to-back frames.
module tb_uart_tx_arbiter;
  localparam int N       = 3;
  localparam int W       = 16;
  localparam int FRAME   = 1800;
  localparam int GAP     = 200;
  localparam int F_SPACE = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic           clr;
  logic [N-1:0]   req;
  logic [N*W-1:0] data_in;
  logic [N-1:0]   grant;
  logic [W-1:0]   tx_data;
  logic           tx_start, busy, done;
  logic [7:0]     sent_cnt;

  logic           clr_f;
  logic [N-1:0]   req_f;
  logic [N*W-1:0] data_f;
  logic [N-1:0]   grant_f;
  logic [W-1:0]   tx_data_f;
  logic           tx_start_f, busy_f, done_f;
  logic [7:0]     sent_cnt_f;

  uart_tx_arbiter #(.N_REQ(N), .WIDTH(W), .BAUD_DIV(100), .GAP_BITS(2)) dut (
    .clk(clk), .clr(clr), .req(req), .data_in(data_in), .grant(grant), .tx_data(tx_data),
    .tx_start(tx_start), .busy(busy), .done(done), .sent_cnt(sent_cnt));

  uart_tx_arbiter #(.N_REQ(N), .WIDTH(W), .BAUD_DIV(1), .GAP_BITS(2)) dut_fast (
    .clk(clk), .clr(clr_f), .req(req_f), .data_in(data_f), .grant(grant_f), .tx_data(tx_data_f),
    .tx_start(tx_start_f), .busy(busy_f), .done(done_f), .sent_cnt(sent_cnt_f));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    logic [N-1:0] g;
    logic [W-1:0] d;
    logic [7:0]   s;
    int           c;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input logic [N-1:0] g, input logic [W-1:0] d, input logic [7:0] s, input int c);
    exp_t e;
    e.g = g; e.d = d; e.s = s; e.c = c;
    sb.push_back(e);
  endtask

  // Main-instance monitor
  int       n_start = 0;
  int       last_start = 0;
  logic [W-1:0] last_word = '0;
  logic     stable_bad = 1'b0;
  logic     bad_pulse = 1'b0;
  logic     busy_prev = 1'b0;
  logic     clr_last = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (tx_start) begin
      n_start++;
      if (sb.size() == 0) begin
        check("unexpected_start", 1, 0);
      end else begin
        e = sb.pop_front();
        check("grant", grant, e.g);
        check("tx_data", tx_data, e.d);
        check("sent_cnt", sent_cnt, e.s);
        check("start_cycle", cyc, e.c);
      end
      last_start = cyc;
      last_word  = tx_data;
      stable_bad = 1'b0;
    end else begin
      if (grant != '0) bad_pulse = 1'b1;
      if (busy && tx_data != last_word) stable_bad = 1'b1;
    end
    if (done) check("done_cycle", cyc, last_start + FRAME);
    if (busy_prev && !busy && !clr_last) begin
      check("busy_release_cycle", cyc, last_start + FRAME + GAP);
      check("tx_data_stable", stable_bad, 0);
    end
    busy_prev = busy;
    clr_last  = clr;
  end

  // Fast-instance monitor: requesters all held, so grants rotate 001,010,100
  int       nf = 0;
  int       f_last = 0;
  logic [W-1:0] f_word = '0;
  logic [W-1:0] f_words [3] = '{16'h0A01, 16'h0B02, 16'h0C03};
  logic     f_bad_space = 1'b0, f_bad_grant = 1'b0, f_bad_data = 1'b0;
  logic     f_bad_cnt = 1'b0, f_bad_stable = 1'b0;

  always @(negedge clk) begin
    if (!clr_f) begin
      if (tx_start_f) begin
        nf++;
        if (nf > 1 && cyc != f_last + F_SPACE) f_bad_space = 1'b1;
        if (grant_f != N'(1 << ((nf - 1) % 3))) f_bad_grant = 1'b1;
        if (tx_data_f != f_words[(nf - 1) % 3]) f_bad_data = 1'b1;
        if (sent_cnt_f != 8'(nf)) f_bad_cnt = 1'b1;
        f_last = cyc;
        f_word = tx_data_f;
      end else if (busy_f && tx_data_f != f_word) begin
        f_bad_stable = 1'b1;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Requester behaviour: drop the granted bit the cycle after grant, run until link is free.
  task automatic run(input int max_cyc);
    int n;
    logic [N-1:0] g;
    n = 0;
    while ((req != '0 || busy) && n < max_cyc) begin
      @(negedge clk);
      g = grant;
      @(posedge clk);
      #1;
      req = req & ~g;
      n++;
    end
    check("drain_timeout", (n >= max_cyc) ? 1 : 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int k;
    clr = 1'b1; req = '0; data_in = '0;
    clr_f = 1'b1; req_f = '0; data_f = {16'h0C03, 16'h0B02, 16'h0A01};

    // Reset and idle
    wait_cycles(2);
    check("rst_grant", grant, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sent_cnt", sent_cnt, 0);
    clr = 1'b0;
    wait_cycles(50);
    check("idle_no_start", n_start, 0);

    // Single request from requester 1
    data_in = {16'h0000, 16'hA5C3, 16'h0000};
    c = cyc;
    req = 3'b010;
    push_exp(3'b010, 16'hA5C3, 8'd1, c + 1);
    run(3000);

    // All three request together after a fresh reset
    clr = 1'b1;
    wait_cycles(1);
    clr = 1'b0;
    data_in = {16'h3333, 16'h2222, 16'h1111};
    c = cyc;
    req = 3'b111;
    push_exp(3'b001, 16'h1111, 8'd1, c + 1);
    push_exp(3'b010, 16'h2222, 8'd2, c + 2002);
    push_exp(3'b100, 16'h3333, 8'd3, c + 4003);
    run(7000);
    check("sent_cnt_after_three", sent_cnt, 3);

    // Requester 0 holds, requester 2 joins mid-frame and must be served next
    data_in = {16'hC004, 16'hB004, 16'hA004};
    c = cyc;
    req = 3'b001;
    push_exp(3'b001, 16'hA004, 8'd4, c + 1);
    wait_cycles(500);
    req = 3'b101;
    push_exp(3'b100, 16'hC004, 8'd5, c + 2002);
    push_exp(3'b001, 16'hA004, 8'd6, c + 4003);
    wait_cycles(1503);
    req = 3'b001;
    wait_cycles(2001);
    req = 3'b000;
    run(3000);

    // Reset mid-frame with ptr=2 beforehand; afterwards ptr restarts at 0
    data_in = {16'h5502, 16'h5501, 16'h5500};
    c = cyc;
    req = 3'b010;
    push_exp(3'b010, 16'h5501, 8'd7, c + 1);
    wait_cycles(1);
    req = 3'b000;
    wait_cycles(499);
    clr = 1'b1;
    wait_cycles(1);
    check("midrst_busy", busy, 0);
    check("midrst_sent_cnt", sent_cnt, 0);
    check("midrst_tx_data", tx_data, 0);
    check("midrst_grant", grant, 0);
    check("midrst_tx_start", tx_start, 0);
    clr = 1'b0;
    c = cyc;
    req = 3'b110;
    push_exp(3'b010, 16'h5501, 8'd1, c + 1);
    push_exp(3'b100, 16'h5502, 8'd2, c + 2002);
    run(5000);

    check("sb_empty", sb.size(), 0);
    check("no_stray_grant", bad_pulse, 0);

    // 256 back-to-back frames on the fast instance
    clr_f = 1'b0;
    req_f = 3'b111;
    k = 0;
    while (nf < 256 && k < 8000) begin
      wait_cycles(1);
      k++;
    end
    req_f = 3'b000;
    wait_cycles(30);
    check("fast_frames", nf, 256);
    check("fast_sent_cnt_wrap", sent_cnt_f, 0);
    check("fast_spacing", f_bad_space, 0);
    check("fast_grant_order", f_bad_grant, 0);
    check("fast_tx_data", f_bad_data, 0);
    check("fast_sent_cnt_seq", f_bad_cnt, 0);
    check("fast_tx_data_stable", f_bad_stable, 0);
    check("fast_busy_end", busy_f, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
